isa_dispatch: RTL

Instruction sequencer upstream of the per-instruction execution units (isa_br and its siblings).
- Owns the instruction pointer and fetches one instruction word per instruction.
- Decodes the opcode, then raises exactly one unit's enable and holds it until that unit reports finished.
- Retires the instruction: takes the unit-supplied IP on a branch, otherwise IP + INSTR_BYTES.

---
 rtl/isa_pkg.sv | 33 +++
 rtl/isa_decode.sv | 29 ++
 rtl/isa_dispatch.sv | 136 +++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared definitions for the instruction sequencer: field layout, states, opcodes.
package isa_pkg;

    localparam int unsigned IP_W    = 64;
    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 8;
    localparam int unsigned REG_W   = 4;

    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 8;
    localparam int unsigned R0_HI  = 7;
    localparam int unsigned R0_LO  = 4;
    localparam int unsigned R1_HI  = 3;
    localparam int unsigned R1_LO  = 0;

    localparam logic [OPC_W-1:0] OPC_BR = 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_RETIRE = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] r0;
        logic [REG_W-1:0] r1;
    } instr_t;

endpackage

// File: rtl/isa_decode.sv
// Combinational instruction decoder: register fields, legality and one-hot unit select.
module isa_decode
    import isa_pkg::*;
#(
    parameter int unsigned NUM_UNITS = 8
) (
    input  logic [INSTR_W-1:0]   instr_i,
    output logic [REG_W-1:0]     r0_o,
    output logic [REG_W-1:0]     r1_o,
    output logic                 legal_o,
    output logic [NUM_UNITS-1:0] sel_o
);

    logic [OPC_W-1:0] opcode;

    assign opcode = instr_i[OPC_HI:OPC_LO];
    assign r0_o   = instr_i[R0_HI:R0_LO];
    assign r1_o   = instr_i[R1_HI:R1_LO];

    // Opcode k selects unit k; anything beyond the last unit is illegal.
    always_comb begin
        legal_o = (32'(opcode) < NUM_UNITS);
        sel_o   = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            sel_o[k] = (32'(opcode) == k);
        end
    end

endmodule

// File: rtl/isa_dispatch.sv
// Instruction sequencer: fetch, decode, hand off to one execution unit, retire and advance IP.
module isa_dispatch
    import isa_pkg::*;
#(
    parameter int unsigned     NUM_UNITS   = 8,
    parameter logic [IP_W-1:0] RESET_IP    = 64'h0,
    parameter int unsigned     INSTR_BYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    output logic [IP_W-1:0]      mem_addr,
    output logic                 mem_re,
    input  logic [INSTR_W-1:0]   mem_data,
    input  logic                 mem_ready,
    output logic [NUM_UNITS-1:0] unit_en,
    input  logic [NUM_UNITS-1:0] unit_finished,
    output logic [REG_W-1:0]     r0,
    output logic [REG_W-1:0]     r1,
    input  logic                 ip_set,
    input  logic [IP_W-1:0]      ip_val,
    output logic [IP_W-1:0]      ip,
    output logic                 fault,
    output logic                 busy
);

    state_e               state_q, state_d;
    instr_t               ir_q, ir_d;
    logic [IP_W-1:0]      ip_q, ip_d;
    logic [IP_W-1:0]      br_target_q, br_target_d;
    logic                 br_taken_q, br_taken_d;
    logic                 mem_re_q, mem_re_d;
    logic [NUM_UNITS-1:0] unit_en_q, unit_en_d;
    logic                 fault_q, fault_d;
    logic                 busy_q, busy_d;

    logic                 dec_legal;
    logic [NUM_UNITS-1:0] dec_sel;

    // Decode always works from the latched instruction so r0/r1 stay stable through EXEC.
    isa_decode #(
        .NUM_UNITS (NUM_UNITS)
    ) u_decode (
        .instr_i (ir_q),
        .r0_o    (r0),
        .r1_o    (r1),
        .legal_o (dec_legal),
        .sel_o   (dec_sel)
    );

    // Next-state logic; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ip_d        = ip_q;
        br_target_d = br_target_q;
        br_taken_d  = br_taken_q;
        fault_d     = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = instr_t'(mem_data);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end
            end
            ST_EXEC: begin
                // Latest ip_set wins, including one arriving with finished.
                if (ip_set) begin
                    br_taken_d  = 1'b1;
                    br_target_d = ip_val;
                end
                if (|(unit_finished & unit_en_q)) state_d = ST_RETIRE;
            end
            ST_RETIRE: begin
                ip_d       = br_taken_q ? br_target_q : ip_q + IP_W'(INSTR_BYTES);
                br_taken_d = 1'b0;
                state_d    = run ? ST_FETCH : ST_IDLE;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_re_d  = (state_d == ST_FETCH);
        unit_en_d = (state_d == ST_EXEC) ? dec_sel : '0;
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_FAULT);
    end

    // State and output registers; reset aborts any in-flight instruction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ir_q        <= '0;
            ip_q        <= RESET_IP;
            br_target_q <= '0;
            br_taken_q  <= 1'b0;
            mem_re_q    <= 1'b0;
            unit_en_q   <= '0;
            fault_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ip_q        <= ip_d;
            br_target_q <= br_target_d;
            br_taken_q  <= br_taken_d;
            mem_re_q    <= mem_re_d;
            unit_en_q   <= unit_en_d;
            fault_q     <= fault_d;
            busy_q      <= busy_d;
        end
    end

    assign ip       = ip_q;
    assign mem_addr = ip_q;
    assign mem_re   = mem_re_q;
    assign unit_en  = unit_en_q;
    assign fault    = fault_q;
    assign busy     = busy_q;

endmodule
